dm_access_ctrl: RTL and testbench
=================================

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 16, data memory word-address width.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter MEM_DEPTH, 65533, implemented words; last valid address is 65532.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_f  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1 / req_ready  out  1  request handshake; transfer when both are 1 at a rising edge.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  ADDR_W / req_wdata  in  DATA_W  request word address and store data.
REQ-009 rsp_valid  out  1 / rsp_ready  in  1  response handshake; response retires when both are 1 at a rising edge.
REQ-010 rsp_rdata  out  DATA_W / rsp_err  out  1  load data (0 for stores) and error flag.
REQ-011 dm_read_addr, dm_write_addr  out  ADDR_W; dm_write_data  out  DATA_W; dm_we  out  1; dm_read_data  in  DATA_W  data-memory port.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, RD_ADDR, WR_SETUP, WR_PULSE, WR_HOLD and RESP; one request is in flight at a time.
REQ-014 req_ready SHALL be 1 only in IDLE.
REQ-015 IDLE + handshake, load: latch the address onto dm_read_addr at edge E0 -> RD_ADDR; at E1 capture dm_read_data into rsp_rdata -> RESP; rsp_valid is high from E1.
REQ-016 IDLE + handshake, store: latch the address and data onto dm_write_addr/dm_write_data at E0 -> WR_SETUP (dm_we=0); E1 -> WR_PULSE (dm_we=1); E2 -> WR_HOLD (dm_we=0; the falling edge commits the write); E3 -> RESP with rsp_rdata=0.
REQ-017 dm_write_addr and dm_write_data SHALL stay stable from E0 through the end of WR_HOLD.
REQ-018 dm_we SHALL be a registered output, high for exactly one cycle per store and never high outside WR_PULSE.
REQ-019 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE; a new request is accepted no earlier than the cycle after retirement.
REQ-020 req_valid or rsp_ready toggling outside IDLE or RESP SHALL have no effect.
REQ-021 dm_read_addr SHALL retain its last value when idle, so the memory is not re-read spuriously.

Reset
REQ-022 rst_f=0 SHALL immediately force: state IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_we=0, dm_read_addr=0, dm_write_addr=0, dm_write_data=0, busy=0.
REQ-023 Reset asserted in WR_PULSE drops dm_we and thereby commits the pending write; this is accepted behaviour, and the response is discarded.
REQ-024 Reset in any other state SHALL leave memory unmodified and discard the request.

Configuration
REQ-025 Macro DM_ACCESS_ADDR_CHK_EN: when defined, a request with req_addr > MEM_DEPTH-1 SHALL skip all dm activity (dm_we stays 0, dm_read_addr unchanged), go IDLE -> RESP at E0 with rsp_err=1 and rsp_rdata=0.
REQ-026 When DM_ACCESS_ADDR_CHK_EN is undefined, rsp_err SHALL be tied to 0 and every address SHALL be forwarded unchanged; out-of-range loads return whatever the memory returns.

Structure
REQ-027 Package sisc_mem_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH and the dm_access_state_t state enum.
REQ-028 The range comparator SHALL be the sub-module dm_addr_chk, instantiated only under DM_ACCESS_ADDR_CHK_EN; the FSM stays in dm_access_ctrl.

Verification
REQ-029 Store addr 0x0003 data 0xDEADBEEF with rsp_ready=1 -> dm_we high for exactly one cycle (E1-E2); dm holds 0xDEADBEEF at word 3; rsp_valid at E3 with rsp_err=0.
REQ-030 Store 0x12345678 to addr 5, then load addr 5 -> rsp_rdata=0x12345678 one cycle after the load handshake.
REQ-031 Load with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; retires the cycle rsp_ready rises.
REQ-032 rst_f pulsed low during WR_SETUP of a store to addr 7 -> word 7 unchanged, all outputs at reset values, the next request is accepted normally.
REQ-033 With DM_ACCESS_ADDR_CHK_EN, load addr 0xFFFE -> rsp_err=1, rsp_rdata=0, no dm_we pulse; without the macro -> rsp_err=0.

Source files
------------

// File: rtl/sisc_mem_pkg.sv
// sisc_mem_pkg: data-memory geometry and access-controller state encoding
package sisc_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int MEM_DEPTH = 65533;
  typedef enum logic [2:0] {IDLE, RD_ADDR, WR_SETUP, WR_PULSE, WR_HOLD, RESP} dm_access_state_t;
endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: request/response handshake between a requester and dm_access_ctrl
interface dm_access_ctrl_if;
  import sisc_mem_pkg::*;
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  modport master(output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_addr, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dm_addr_chk.sv
// dm_addr_chk: flags word addresses that fall inside the implemented memory
module dm_addr_chk
  import sisc_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  assign in_range = addr <= LAST;
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: one-at-a-time load/store sequencer with a registered write strobe.
// Define DM_ACCESS_ADDR_CHK_EN to reject out-of-range addresses with rsp_err.
module dm_access_ctrl
  import sisc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_f,
  dm_access_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] dm_read_addr,
  output logic [ADDR_W-1:0] dm_write_addr,
  output logic [DATA_W-1:0] dm_write_data,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_read_data,
  output logic              busy
);
  dm_access_state_t state, next;
  logic [DATA_W-1:0] rdata;
  logic err, bad, acc;
`ifdef DM_ACCESS_ADDR_CHK_EN
  logic in_range;
  dm_addr_chk u_addr_chk (.addr(bus.req_addr), .in_range(in_range));
  assign bad = !in_range;
  assign bus.rsp_err = err;
`else
  assign bad = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  assign acc = state == IDLE && bus.req_valid;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign busy = state != IDLE;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:     next = !bus.req_valid ? IDLE : bad ? RESP : bus.req_we ? WR_SETUP : RD_ADDR;
      RD_ADDR:  next = RESP;
      WR_SETUP: next = WR_PULSE;
      WR_PULSE: next = WR_HOLD;
      WR_HOLD:  next = RESP;
      RESP:     next = bus.rsp_ready ? IDLE : RESP;
      default:  next = IDLE;
    endcase
  end
  // dm_we comes from its own flop, decoded from next, so it is glitch-free for the memory
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= IDLE;
      dm_we <= 1'b0;
      dm_read_addr <= '0;
      dm_write_addr <= '0;
      dm_write_data <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      dm_we <= next == WR_PULSE;
      if (acc && !bad && bus.req_we) begin
        dm_write_addr <= bus.req_addr;
        dm_write_data <= bus.req_wdata;
      end
      if (acc && !bad && !bus.req_we) dm_read_addr <= bus.req_addr;
      if (acc) begin
        rdata <= '0;
        err <= bad;
      end
      if (state == RD_ADDR) rdata <= dm_read_data;
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: vector table, reset corner cases and random traffic against a memory model
module tb_dm_access_ctrl;
  import sisc_mem_pkg::*;
`ifdef DM_ACCESS_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                dly;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  logic [ADDR_W-1:0] dm_read_addr, dm_write_addr, last_rd, pa;
  logic [DATA_W-1:0] dm_write_data, dm_read_data, pd;
  logic dm_we, busy;
  logic armed = 1'b0;
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  int checks = 0;
  int errors = 0;

  dm_access_ctrl_if bus();
  dm_access_ctrl dut (
    .clk(clk), .rst_f(rst_f), .bus(bus),
    .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr),
    .dm_write_data(dm_write_data), .dm_we(dm_we),
    .dm_read_data(dm_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory: asynchronous read, write committed on the falling edge of dm_we
  assign dm_read_data = mem[dm_read_addr];
  always @(posedge dm_we) begin
    pa = dm_write_addr;
    pd = dm_write_data;
    armed = 1'b1;
  end
  always @(negedge dm_we) if (armed) begin
    mem[pa] = pd;
    armed = 1'b0;
  end

  function automatic logic [DATA_W-1:0] init_val(int a);
    return 32'h9E37_79B9 * a + 32'h0000_1234;
  endfunction

  function automatic bit ok_addr(logic [ADDR_W-1:0] a);
    return !CHK || int'(a) <= MEM_DEPTH - 1;
  endfunction

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input int dly, input logic [DATA_W-1:0] exp_rdata, input logic exp_err);
    logic [DATA_W-1:0] r;
    logic e;
    int lat, pulses;
    bit ok, wr_ok, hold_ok;
    ok = ok_addr(addr);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    pulses = int'(dm_we);
    wr_ok = !(we && ok && (dm_write_addr !== addr || dm_write_data !== wdata));
    hold_ok = 1'b1;
    chkb("busy", busy, 1'b1);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      bus.req_valid = 1'($urandom);
      bus.req_we = 1'($urandom);
      bus.req_addr = ADDR_W'($urandom);
      bus.req_wdata = $urandom;
      bus.rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      pulses += int'(dm_we);
      if (we && ok && (dm_write_addr !== addr || dm_write_data !== wdata)) wr_ok = 1'b0;
    end
    chk("latency", lat, !ok ? 0 : we ? 3 : 1);
    chk("we_cycles", pulses, (we && ok) ? 1 : 0);
    chk("rdata", bus.rsp_rdata, exp_rdata);
    chkb("err", bus.rsp_err, exp_err);
    chkb("wr_stable", wr_ok, 1'b1);
    r = bus.rsp_rdata;
    e = bus.rsp_err;
    repeat (dly) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'($urandom);
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r || bus.rsp_err !== e || bus.req_ready !== 1'b0)
        hold_ok = 1'b0;
    end
    chkb("rsp_hold", hold_ok, 1'b1);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chkb("retire", !bus.rsp_valid && bus.req_ready && !busy, 1'b1);
    if (ok && we) ref_mem[addr] = wdata;
    if (ok && !we) last_rd = addr;
    chk("rd_addr", 32'(dm_read_addr), 32'(last_rd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic we, ok;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int idx;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    last_rd = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    #12;
    chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chkb("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chkb("rst_dm_we", dm_we, 1'b0);
    chk("rst_rd_addr", 32'(dm_read_addr), '0);
    chk("rst_wr_addr", 32'(dm_write_addr), '0);
    chk("rst_wr_data", dm_write_data, '0);
    chkb("rst_busy", busy, 1'b0);
    @(negedge clk) rst_f = 1'b1;
    @(posedge clk); #1;
    chkb("ready_after_rst", bus.req_ready, 1'b1);

    tbl.push_back('{1'b1, 16'h0003, 32'hDEADBEEF, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 16'h0005, 32'h12345678, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 16'h0005, 32'h0, 0, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 16'h0003, 32'h0, 4, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 32'h0, 1, init_val(0), 1'b0});
    tbl.push_back('{1'b1, 16'hFFFC, 32'hA5A55A5A, 2, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 16'hFFFC, 32'h0, 0, 32'hA5A55A5A, 1'b0});
    tbl.push_back('{1'b0, 16'hFFFE, 32'h0, 1, CHK ? 32'h0 : init_val(16'hFFFE), CHK});
    tbl.push_back('{1'b1, 16'hFFFF, 32'h11112222, 0, 32'h0, CHK});
    tbl.push_back('{1'b0, 16'hFFFF, 32'h0, 0, CHK ? 32'h0 : 32'h11112222, CHK});
    tbl.push_back('{1'b1, 16'h0005, 32'hCAFEF00D, 2, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 16'h0005, 32'h0, 3, 32'hCAFEF00D, 1'b0});
    foreach (tbl[i]) do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dly, tbl[i].exp_rdata, tbl[i].exp_err);
    chk("mem3", mem[3], 32'hDEADBEEF);

    // reset while the store to word 7 is still in setup: no write may happen
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 16'h0007;
    bus.req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chkb("setup_we", dm_we, 1'b0);
    #2 rst_f = 1'b0;
    #1;
    chkb("rst_setup_busy", busy, 1'b0);
    chkb("rst_setup_we", dm_we, 1'b0);
    chk("rst_setup_wa", 32'(dm_write_addr), '0);
    chk("rst_setup_wd", dm_write_data, '0);
    chkb("rst_setup_rv", bus.rsp_valid, 1'b0);
    @(negedge clk) rst_f = 1'b1;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_setup_mem7", mem[7], init_val(7));
    do_req(1'b0, 16'h0007, 32'h0, 0, init_val(7), 1'b0);

    // reset during the strobe: the falling dm_we commits the pending write
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 16'h0009;
    bus.req_wdata = 32'h600DCAFE;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chkb("pulse_we", dm_we, 1'b1);
    #2 rst_f = 1'b0;
    #1;
    chkb("rst_pulse_we", dm_we, 1'b0);
    chk("rst_pulse_mem9", mem[9], 32'h600DCAFE);
    ref_mem[9] = 32'h600DCAFE;
    @(negedge clk) rst_f = 1'b1;
    last_rd = '0;
    do_req(1'b0, 16'h0009, 32'h0, 0, 32'h600DCAFE, 1'b0);

    repeat (300) begin
      we = 1'($urandom);
      idx = $urandom_range(0, 23);
      addr = idx < 16 ? ADDR_W'(idx) : ADDR_W'(65528 + idx - 16);
      wdata = $urandom;
      ok = ok_addr(addr);
      do_req(we, addr, wdata, $urandom_range(0, 3), (!ok || we) ? 32'h0 : ref_mem[addr], !ok);
    end
    for (int i = 0; i < 24; i++) begin
      addr = i < 16 ? ADDR_W'(i) : ADDR_W'(65528 + i - 16);
      chk("mem_final", mem[addr], ref_mem[addr]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
